// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared definitions for the instruction fetch slice: the fetch state
// encoding and the default widths / reset PC / watchdog limit used by
// fetch_unit and pc_counter.
// Ports: none (package).
// Build option: FETCH_TIMEOUT_EN (consumed by fetch_unit only).
package fetch_pkg;

  // IDLE: nothing pending, REQ: read outstanding, HOLD: word buffered
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam int DEF_AW       = 8;
  localparam int DEF_DW       = 8;
  localparam int DEF_RESET_PC = 0;
  localparam int DEF_TIMEOUT  = 15;

endpackage

// File: rtl/fetch_unit_pc_counter.sv
// pc_counter
// Program counter register. On i_advance the PC moves to the word after
// the address being fetched, where that address is either the jump target
// (i_jmp_en) or the current PC. Otherwise the PC holds.
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-low reset (PC <= RESET_PC)
//   i_advance    in   a fetch is being launched this cycle
//   i_jmp_en     in   fetch from i_jmp_addr instead of the PC
//   i_jmp_addr   in   jump target
//   o_fetch_addr out  address of the fetch launched this cycle (combinational)
//   o_pc         out  current program counter
module pc_counter
  import fetch_pkg::*;
#(
  parameter int            AW       = DEF_AW,
  parameter logic [AW-1:0] RESET_PC = AW'(DEF_RESET_PC)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_advance,
  input  logic          i_jmp_en,
  input  logic [AW-1:0] i_jmp_addr,
  output logic [AW-1:0] o_fetch_addr,
  output logic [AW-1:0] o_pc
);

  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_fetch_addr;

  assign w_fetch_addr = i_jmp_en ? i_jmp_addr : r_pc;

  // Increment wraps naturally at 2^AW because the sum is truncated to AW bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= RESET_PC;
    end else if (i_advance) begin
      r_pc <= w_fetch_addr + AW'(1);
    end
  end

  assign o_fetch_addr = w_fetch_addr;
  assign o_pc         = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Owns the PC and the instruction register. Each accepted pc_en strobe
// issues one memory read over a req/ack handshake; the returned word is
// buffered and committed to IR on ir_en (or bypassed straight to IR when
// ack and ir_en coincide). Strobe-order violations set a sticky fetch_err.
// Build option: define FETCH_TIMEOUT_EN to add a watchdog that aborts a
// read left unacknowledged for TIMEOUT cycles and sets sticky timeout_err.
// Ports:
//   clk, rst (async, active-low)
//   i_pc_en, i_ir_en     phase strobes from the timing generator
//   i_halt               masks i_pc_en, PC frozen
//   i_jmp_en, i_jmp_addr jump request, sampled with i_pc_en
//   o_mem_req, o_mem_addr, i_mem_ack, i_mem_rdata  memory read handshake
//   o_pc, o_ir, o_ir_valid                         fetch results
//   o_fetch_err, o_timeout_err                     sticky error flags
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int            AW       = DEF_AW,
  parameter int            DW       = DEF_DW,
  parameter logic [AW-1:0] RESET_PC = AW'(DEF_RESET_PC),
  parameter int            TIMEOUT  = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_pc_en,
  input  logic          i_ir_en,
  input  logic          i_halt,
  input  logic          i_jmp_en,
  input  logic [AW-1:0] i_jmp_addr,
  output logic          o_mem_req,
  output logic [AW-1:0] o_mem_addr,
  input  logic          i_mem_ack,
  input  logic [DW-1:0] i_mem_rdata,
  output logic [AW-1:0] o_pc,
  output logic [DW-1:0] o_ir,
  output logic          o_ir_valid,
  output logic          o_fetch_err,
  output logic          o_timeout_err
);

  fetch_state_t  r_state;
  logic          r_mem_req;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_ir;
  logic          r_ir_valid;
  logic          r_fetch_err;
  logic [DW-1:0] r_buf;

  logic          w_pc_en_live;
  logic          w_launch;
  logic          w_timeout;
  logic [AW-1:0] w_fetch_addr;
  logic [AW-1:0] w_pc;

  // halt masks the fetch strobe entirely; a new fetch may start from IDLE or
  // HOLD (the latter drops the buffered word) but never while a read is out
  assign w_pc_en_live = i_pc_en && !i_halt;
  assign w_launch     = w_pc_en_live && (r_state != REQ);

  pc_counter #(
    .AW       (AW),
    .RESET_PC (RESET_PC)
  ) u_pc_counter (
    .clk          (clk),
    .rst          (rst),
    .i_advance    (w_launch),
    .i_jmp_en     (i_jmp_en),
    .i_jmp_addr   (i_jmp_addr),
    .o_fetch_addr (w_fetch_addr),
    .o_pc         (w_pc)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout_err;

  // r_cnt holds the number of completed REQ cycles, so the abort fires on
  // the TIMEOUT-th cycle spent waiting for an ack
  assign w_timeout = (r_state == REQ) && !i_mem_ack &&
                     (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_launch) begin
      r_cnt <= '0;
    end else if ((r_state == REQ) && !i_mem_ack) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timeout_err <= 1'b0;
    end else if (w_timeout) begin
      r_timeout_err <= 1'b1;
    end
  end

  assign o_timeout_err = r_timeout_err;
`else
  // No watchdog: a read waits for its ack indefinitely and the flag is
  // constant low for any legal (non-negative) TIMEOUT
  assign w_timeout     = 1'b0;
  assign o_timeout_err = (TIMEOUT < 0);
`endif

  // Fetch sequencer. ir_valid defaults low so every commit is a single
  // cycle pulse. In HOLD a fresh pc_en wins over a coincident ir_en: the
  // buffered word is abandoned and the new read starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_ir        <= '0;
      r_ir_valid  <= 1'b0;
      r_fetch_err <= 1'b0;
      r_buf       <= '0;
    end else begin
      r_ir_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_ir_en) begin
            r_fetch_err <= 1'b1;
          end
          if (w_pc_en_live) begin
            r_mem_addr <= w_fetch_addr;
            r_mem_req  <= 1'b1;
            r_state    <= REQ;
          end
        end
        REQ: begin
          if (w_pc_en_live) begin
            r_fetch_err <= 1'b1;
          end
          if (i_mem_ack) begin
            r_mem_req <= 1'b0;
            if (i_ir_en) begin
              r_ir       <= i_mem_rdata;
              r_ir_valid <= 1'b1;
              r_state    <= IDLE;
            end else begin
              r_buf   <= i_mem_rdata;
              r_state <= HOLD;
            end
          end else begin
            if (i_ir_en) begin
              r_fetch_err <= 1'b1;
            end
            if (w_timeout) begin
              r_mem_req <= 1'b0;
              r_state   <= IDLE;
            end
          end
        end
        HOLD: begin
          if (w_pc_en_live) begin
            r_fetch_err <= 1'b1;
            r_mem_addr  <= w_fetch_addr;
            r_mem_req   <= 1'b1;
            r_state     <= REQ;
          end else if (i_ir_en) begin
            r_ir       <= r_buf;
            r_ir_valid <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign o_mem_req   = r_mem_req;
  assign o_mem_addr  = r_mem_addr;
  assign o_pc        = w_pc;
  assign o_ir        = r_ir;
  assign o_ir_valid  = r_ir_valid;
  assign o_fetch_err = r_fetch_err;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Self-checking bench for fetch_unit: directed scenarios followed by
// randomized strobe / handshake traffic, all compared against a
// transaction-level reference model. Works with or without FETCH_TIMEOUT_EN.
module tb_fetch_unit;

  localparam int TIMEOUT = 15;

  logic       clk;
  logic       rst;
  logic       pcEn;
  logic       irEn;
  logic       halt;
  logic       jmpEn;
  logic [7:0] jmpAddr;
  logic       memReq;
  logic [7:0] memAddr;
  logic       memAck;
  logic [7:0] memRdata;
  logic [7:0] pc;
  logic [7:0] ir;
  logic       irValid;
  logic       fetchErr;
  logic       timeoutErr;

  int checkCount;
  int passCount;

  // Reference model: what the unit has promised so far
  logic [7:0] mPc;
  logic [7:0] mAddr;
  logic [7:0] mIr;
  logic [7:0] mBuf;
  bit         mReadOut;
  bit         mWordHeld;
  bit         mIrValid;
  bit         mFetchErr;
  bit         mTimeoutErr;
  int         mWait;

  fetch_unit #(
    .AW       (8),
    .DW       (8),
    .RESET_PC (8'h00),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_pc_en       (pcEn),
    .i_ir_en       (irEn),
    .i_halt        (halt),
    .i_jmp_en      (jmpEn),
    .i_jmp_addr    (jmpAddr),
    .o_mem_req     (memReq),
    .o_mem_addr    (memAddr),
    .i_mem_ack     (memAck),
    .i_mem_rdata   (memRdata),
    .o_pc          (pc),
    .o_ir          (ir),
    .o_ir_valid    (irValid),
    .o_fetch_err   (fetchErr),
    .o_timeout_err (timeoutErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount = checkCount + 1;
    assert (obs === exp) passCount = passCount + 1;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".mem_req"},     32'(memReq),     32'(mReadOut));
    checkVal({tag, ".mem_addr"},    32'(memAddr),    32'(mAddr));
    checkVal({tag, ".pc"},          32'(pc),         32'(mPc));
    checkVal({tag, ".ir"},          32'(ir),         32'(mIr));
    checkVal({tag, ".ir_valid"},    32'(irValid),    32'(mIrValid));
    checkVal({tag, ".fetch_err"},   32'(fetchErr),   32'(mFetchErr));
    checkVal({tag, ".timeout_err"}, 32'(timeoutErr), 32'(mTimeoutErr));
  endtask

  task automatic modelReset();
    mPc         = 8'h00;
    mAddr       = 8'h00;
    mIr         = 8'h00;
    mBuf        = 8'h00;
    mReadOut    = 1'b0;
    mWordHeld   = 1'b0;
    mIrValid    = 1'b0;
    mFetchErr   = 1'b0;
    mTimeoutErr = 1'b0;
    mWait       = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied
  task automatic modelStep();
    bit fetchReq;
    fetchReq = pcEn && !halt;
    mIrValid = 1'b0;
    if (mReadOut) begin
      if (fetchReq) mFetchErr = 1'b1;
      if (memAck) begin
        mReadOut = 1'b0;
        if (irEn) begin
          mIr      = memRdata;
          mIrValid = 1'b1;
        end else begin
          mBuf      = memRdata;
          mWordHeld = 1'b1;
        end
      end else begin
        if (irEn) mFetchErr = 1'b1;
        mWait = mWait + 1;
`ifdef FETCH_TIMEOUT_EN
        if (mWait == TIMEOUT) begin
          mReadOut    = 1'b0;
          mTimeoutErr = 1'b1;
        end
`endif
      end
    end else if (fetchReq) begin
      if (irEn && !mWordHeld) mFetchErr = 1'b1;
      if (mWordHeld) mFetchErr = 1'b1;
      mWordHeld = 1'b0;
      mAddr     = jmpEn ? jmpAddr : mPc;
      mPc       = mAddr + 8'd1;
      mReadOut  = 1'b1;
      mWait     = 0;
    end else if (irEn) begin
      if (mWordHeld) begin
        mIr       = mBuf;
        mIrValid  = 1'b1;
        mWordHeld = 1'b0;
      end else begin
        mFetchErr = 1'b1;
      end
    end
  endtask

  task automatic applyStimulus(input logic p, input logic i, input logic h, input logic j,
                               input logic [7:0] ja, input logic a, input logic [7:0] rd,
                               input string tag);
    pcEn     = p;
    irEn     = i;
    halt     = h;
    jmpEn    = j;
    jmpAddr  = ja;
    memAck   = a;
    memRdata = rd;
    modelStep();
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic idleCycle(input string tag);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, tag);
  endtask

  // Asynchronous reset asserted mid-cycle, checked while still held low
  task automatic applyReset(input string tag);
    pcEn   = 1'b0;
    irEn   = 1'b0;
    halt   = 1'b0;
    jmpEn  = 1'b0;
    memAck = 1'b0;
    rst    = 1'b0;
    #1;
    modelReset();
    checkOutput(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst        = 1'b0;
    pcEn       = 1'b0;
    irEn       = 1'b0;
    halt       = 1'b0;
    jmpEn      = 1'b0;
    jmpAddr    = 8'h00;
    memAck     = 1'b0;
    memRdata   = 8'h00;
    modelReset();
    #2;
    applyReset("reset");
    checkVal("resetPc", 32'(pc), 32'h00);
    checkVal("resetMemReq", 32'(memReq), 32'h0);

    // Basic fetch: launch at pc 0, ack two cycles later, then commit
    applyStimulus(1, 0, 0, 0, 8'h00, 0, 8'h00, "t1Launch");
    checkVal("t1MemAddr", 32'(memAddr), 32'h00);
    checkVal("t1Pc", 32'(pc), 32'h01);
    checkVal("t1MemReq", 32'(memReq), 32'h1);
    idleCycle("t1Wait");
    applyStimulus(0, 0, 0, 0, 8'h00, 1, 8'hA5, "t1Ack");
    checkVal("t1ReqDrop", 32'(memReq), 32'h0);
    applyStimulus(0, 1, 0, 0, 8'h00, 0, 8'h00, "t1Commit");
    checkVal("t1Ir", 32'(ir), 32'hA5);
    checkVal("t1IrValid", 32'(irValid), 32'h1);
    idleCycle("t1After");
    checkVal("t1IrValidPulse", 32'(irValid), 32'h0);
    checkVal("t1FetchErr", 32'(fetchErr), 32'h0);

    // Jump fetch, completed with ack and ir_en in the same cycle
    applyStimulus(1, 0, 0, 1, 8'h40, 0, 8'h00, "t2Jump");
    checkVal("t2MemAddr", 32'(memAddr), 32'h40);
    checkVal("t2Pc", 32'(pc), 32'h41);
    applyStimulus(0, 1, 0, 0, 8'h00, 1, 8'h3C, "t4Bypass");
    checkVal("t4Ir", 32'(ir), 32'h3C);
    checkVal("t4IrValid", 32'(irValid), 32'h1);
    checkVal("t4MemReq", 32'(memReq), 32'h0);
    checkVal("t4FetchErr", 32'(fetchErr), 32'h0);

    // PC wrap from 8'hFF
    applyStimulus(1, 0, 0, 1, 8'hFE, 0, 8'h00, "t3Jump");
    applyStimulus(0, 1, 0, 0, 8'h00, 1, 8'h11, "t3Bypass");
    checkVal("t3PcFF", 32'(pc), 32'hFF);
    applyStimulus(1, 0, 0, 0, 8'h00, 0, 8'h00, "t3Wrap");
    checkVal("t3MemAddr", 32'(memAddr), 32'hFF);
    checkVal("t3Pc", 32'(pc), 32'h00);
    applyStimulus(0, 0, 0, 0, 8'h00, 1, 8'h22, "t3AckHold");
    applyStimulus(0, 1, 0, 0, 8'h00, 0, 8'h00, "t3Commit");
    checkVal("t3Ir", 32'(ir), 32'h22);

    // halt masks pc_en without flagging an error
    applyStimulus(1, 0, 1, 0, 8'h00, 0, 8'h00, "t5Halt");
    checkVal("t5HaltReq", 32'(memReq), 32'h0);
    checkVal("t5HaltPc", 32'(pc), 32'h00);
    checkVal("t5HaltErr", 32'(fetchErr), 32'h0);

    // Protocol errors while a read is outstanding
    applyStimulus(1, 0, 0, 0, 8'h00, 0, 8'h00, "t5Launch");
    applyStimulus(0, 1, 0, 0, 8'h00, 0, 8'h00, "t5EarlyIr");
    checkVal("t5FetchErr", 32'(fetchErr), 32'h1);
    checkVal("t5IrKept", 32'(ir), 32'h22);
    applyStimulus(1, 0, 0, 1, 8'h80, 0, 8'h00, "t5PcEnInReq");
    checkVal("t5ReqAddr", 32'(memAddr), 32'h00);
    checkVal("t5ReqPc", 32'(pc), 32'h01);
    applyStimulus(0, 0, 0, 0, 8'h00, 1, 8'h33, "t5LateAck");
    applyStimulus(1, 0, 0, 0, 8'h00, 0, 8'h00, "t5DropHold");
    checkVal("t5DropReq", 32'(memReq), 32'h1);
    checkVal("t5DropAddr", 32'(memAddr), 32'h01);
    applyStimulus(0, 1, 0, 0, 8'h00, 1, 8'h44, "t5NewWord");
    checkVal("t5NewIr", 32'(ir), 32'h44);

    // Reset while a read is outstanding
    applyStimulus(1, 0, 0, 0, 8'h00, 0, 8'h00, "t6Launch");
    applyReset("t6MidReqReset");
    checkVal("t6MemReqDrop", 32'(memReq), 32'h0);
    checkVal("t6ErrCleared", 32'(fetchErr), 32'h0);

    // Unanswered read
    applyStimulus(1, 0, 0, 0, 8'h00, 0, 8'h00, "t6Stall");
    for (int k = 0; k < TIMEOUT + 4; k++) idleCycle("t6Wait");
`ifdef FETCH_TIMEOUT_EN
    checkVal("t6TimeoutReq", 32'(memReq), 32'h0);
    checkVal("t6TimeoutErr", 32'(timeoutErr), 32'h1);
    applyStimulus(0, 1, 0, 0, 8'h00, 1, 8'h55, "t6StrayAck");
    checkVal("t6StrayIr", 32'(ir), 32'h00);
`else
    checkVal("t6StillReq", 32'(memReq), 32'h1);
    checkVal("t6NoTimeout", 32'(timeoutErr), 32'h0);
`endif
    applyReset("t6Reset");

    // Randomized traffic with periodic resets to clear sticky flags
    for (int n = 0; n < 800; n++) begin
      if ((n % 160) == 159) begin
        applyReset("rndReset");
      end else begin
        applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                      8'($urandom), ($urandom_range(0, 2) == 0), 8'($urandom),
                      "rnd");
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
